// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: chain of DEPTH handshaked pipeline registers of width N.
// Each stage advances whenever it is empty or the stage after it can advance,
// so bubbles collapse under back-pressure. A synchronous flush clears every
// valid bit while holding data. count is the registered number of valid stages.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous clear of all valid bits, blocks both handshakes
//   in_valid   upstream word present
//   in_ready   chain accepts the upstream word this cycle
//   in_data    upstream word
//   out_valid  last stage holds a word
//   out_ready  downstream accepts the word this cycle
//   out_data   data of last stage (driven regardless of valid)
//   count      number of valid stages, 0..DEPTH
module pipe_reg_chain #(
  parameter int unsigned   N           = 32,
  parameter int unsigned   DEPTH       = 2,
  parameter logic [N-1:0]  RESET_VALUE = '0,
  localparam int unsigned  CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] data_en;
  logic [N-1:0]     data_q [DEPTH];
  logic [N-1:0]     data_src [DEPTH+1];
  logic [DEPTH:0]   valid_src;
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count_d;

  // Ready propagates backwards: a stage may load if it, or any stage after it,
  // is empty, or the downstream consumer is taking the last word. Accumulating
  // in a local avoids a self-referencing vector.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~valid_q[i];
      rdy[i] = acc;
    end
  end

  // Source of each stage: index 0 is the upstream port, index i+1 is stage i.
  always_comb begin
    valid_src    = {valid_q, in_valid};
    data_src[0]  = in_data;
    for (int i = 0; i < DEPTH; i++) begin
      data_src[i+1] = data_q[i];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_en = '0;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_d[i] = valid_src[i];
          // Bubbles move the valid bit only, so data stays deterministic.
          data_en[i] = valid_src[i];
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count   <= '0;
    end else begin
      valid_q <= valid_d;
      count   <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (data_en[i]) begin
          data_q[i] <= data_src[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  pipe_reg_chain #(
    .N           (N),
    .DEPTH       (DEPTH),
    .RESET_VALUE (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
      bad++;
      $display("FAIL reset_preload: out_valid=%b out_data=%h want 1 12345678", out_valid, out_data);
    end
    // Assert reset between clock edges; effect must be immediate.
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (count !== 2'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    total++;
    if (out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL lat_in_ready: got %b want 1", in_ready);
    end
    cyc();  // deadbeef accepted
    in_data = 32'hcafebabe;
    cyc();  // cafebabe accepted
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || count !== 2'd2) begin
      bad++;
      $display("FAIL lat_early: out_valid=%b count=%0d want 0 2", out_valid, count);
    end
    cyc();  // third edge after deadbeef acceptance
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hdeadbeef || count !== 2'd2) begin
      bad++;
      $display("FAIL lat_first: out_valid=%b out_data=%h count=%0d want 1 deadbeef 2",
               out_valid, out_data, count);
    end
    cyc();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hcafebabe || count !== 2'd1) begin
      bad++;
      $display("FAIL lat_second: out_valid=%b out_data=%h count=%0d want 1 cafebabe 1",
               out_valid, out_data, count);
    end
    cyc();
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'hcafebabe || count !== 2'd0) begin
      bad++;
      $display("FAIL lat_empty: out_valid=%b out_data=%h count=%0d want 0 cafebabe 0",
               out_valid, out_data, count);
    end
  endtask

  task automatic test_backpressure();
    int v   = 1;
    int exp = 1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = v;
      #1;
      total++;
      if (in_ready !== (k < 3)) begin
        bad++;
        $display("FAIL bp_in_ready_%0d: got %b want %b", k, in_ready, k < 3);
      end
      if (in_ready) v++;
      cyc();
    end
    total++;
    if (count !== 2'd3 || out_valid !== 1'b1 || out_data !== 32'd1) begin
      bad++;
      $display("FAIL bp_full: count=%0d out_valid=%b out_data=%0d want 3 1 1",
               count, out_valid, out_data);
    end
    // Release and collect every word, bounded.
    for (int k = 0; k < 20 && exp <= 5; k++) begin
      out_ready = 1'b1;
      in_valid  = (v <= 5);
      in_data   = v;
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== exp) begin
          bad++;
          $display("FAIL bp_order: got %0d want %0d", out_data, exp);
        end
        exp++;
      end
      if (in_valid && in_ready) v++;
      cyc();
    end
    in_valid = 1'b0;
    total++;
    if (exp != 6 || v != 6) begin
      bad++;
      $display("FAIL bp_drain: received up to %0d accepted up to %0d want 6 6", exp, v);
    end
  endtask

  task automatic test_bubble_flush();
    cyc();
    total++;
    if (count !== 2'd0) begin
      bad++;
      $display("FAIL bub_start_count: got %0d want 0", count);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    in_valid = 1'b1;
    in_data  = 32'd2;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    total++;
    if (count !== 2'd2 || in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'd1) begin
      bad++;
      $display("FAIL bub_packed: count=%0d in_ready=%b out_valid=%b out_data=%0d want 2 1 1 1",
               count, in_ready, out_valid, out_data);
    end
    // Top up to full, then flush with both handshakes requested.
    in_valid = 1'b1;
    in_data  = 32'd3;
    cyc();
    total++;
    if (count !== 2'd3 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_prefill: count=%0d in_ready=%b want 3 0", count, in_ready);
    end
    in_data   = 32'd99;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_block: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'd1) begin
      bad++;
      $display("FAIL flush_after: count=%0d out_valid=%b out_data=%0d want 0 0 1",
               count, out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 100 + k;
      cyc();
    end
    total++;
    if (count !== 2'd3) begin
      bad++;
      $display("FAIL b2b_fill: count=%0d want 3", count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 103 + k;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'(100 + k)) begin
        bad++;
        $display("FAIL b2b_cycle_%0d: in_ready=%b out_valid=%b out_data=%0d want 1 1 %0d",
                 k, in_ready, out_valid, out_data, 100 + k);
      end
      cyc();
      total++;
      if (count !== 2'd3) begin
        bad++;
        $display("FAIL b2b_count_%0d: got %0d want 3", k, count);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
